wb_sram_burst_slave: RTL and testbench

- Single-port on-chip SRAM that presents a Wishbone slave port.
- Sits directly downstream of one slave port of the 2-master/3-slave Wishbone interconnect, typically s0, as the system memory.
- Supports classic single accesses and registered-feedback incrementing bursts: CTI=010 with BTE linear, wrap4, wrap8 or wrap16.
- Flags out-of-window and mis-sequenced burst addresses with ERR.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_if.sv | 28 ++
 rtl/wb_burst_addr_gen.sv | 30 +++
 rtl/wb_sram_burst_slave.sv | 151 +++++++++++++++
 tb/tb_wb_sram_burst_slave.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type and burst-type codes, slave FSM states
// and the byte-offset helper used to turn byte addresses into word indices.
package wb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } wb_cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } wb_bte_e;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        CLASSIC_ACK = 2'b01,
        BURST       = 2'b10
    } wb_slave_state_e;

    // Number of byte-address bits below the word index.
    function automatic int wb_offs_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 point-to-point bundle. Handshake: a request is presented while
// cyc&stb are high; the slave answers with exactly one of ack/err per accepted beat.
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-word generator for incrementing bursts: linear wraps over the
// whole index space, wrap4/8/16 increment only the low bits and hold the rest.
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int IDX_WIDTH = 12
) (
    input  logic [IDX_WIDTH-1:0] idx,
    input  wb_bte_e              bte,
    output logic [IDX_WIDTH-1:0] next_idx
);

    logic [IDX_WIDTH-1:0] inc;
    logic [IDX_WIDTH-1:0] mask;

    always_comb begin
        inc  = idx + IDX_WIDTH'(1);
        mask = '1;
        case (bte)
            LINEAR: mask = '1;
            WRAP4:  mask = IDX_WIDTH'(3);
            WRAP8:  mask = IDX_WIDTH'(7);
            WRAP16: mask = IDX_WIDTH'(15);
            default: mask = '1;
        endcase
        // Bits outside the wrap window come from the current index untouched.
        next_idx = (idx & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/wb_sram_burst_slave.sv
// Single-port SRAM behind a Wishbone slave port with classic cycles and
// registered-feedback incrementing bursts; address faults answer with err.
module wb_sram_burst_slave
    import wb_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       MEM_WORDS_LOG2 = 12,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic            clk,
    input  logic            rstn,
    wb_if.slave             s,
    output wb_slave_state_e state
);

    localparam int OFFS     = wb_offs_bits(WB_DATA_WIDTH);
    localparam int IW       = MEM_WORDS_LOG2;
    localparam int LANES    = WB_DATA_WIDTH / 8;
    localparam int WIN_BITS = IW + OFFS;
    localparam int WAW      = WB_ADDR_WIDTH - OFFS;

    logic [WB_DATA_WIDTH-1:0] mem [2**IW];

    wb_slave_state_e state_n;
    logic [IW-1:0]   cnt;
    logic [IW-1:0]   cnt_n;
    wb_bte_e         bte_q;
    wb_bte_e         bte_n;
    logic            ack_n;
    logic            err_n;
    logic            acc_en;
    logic [IW-1:0]   acc_idx;

    logic [WB_ADDR_WIDTH-1:0] rel_adr;
    logic                     in_range;
    logic [IW-1:0]            widx;
    logic [WAW-1:0]           cnt_wadr;
    logic                     adr_match;
    logic [IW-1:0]            gen_idx;
    logic [IW-1:0]            gen_next;
    wb_bte_e                  gen_bte;

    assign rel_adr  = s.adr - BASE_ADDR;
    assign in_range = (s.adr >= BASE_ADDR) && ((rel_adr >> WIN_BITS) == '0);
    assign widx     = rel_adr[OFFS +: IW];

    // Word address the master must present for the current burst beat.
    assign cnt_wadr  = BASE_ADDR[WB_ADDR_WIDTH-1:OFFS] + WAW'(cnt);
    assign adr_match = (s.adr[WB_ADDR_WIDTH-1:OFFS] == cnt_wadr);

    // In IDLE the generator predicts beat 2 from the request; in BURST it advances the counter.
    assign gen_idx = (state == BURST) ? cnt : widx;
    assign gen_bte = (state == BURST) ? bte_q : wb_bte_e'(s.bte);

    wb_burst_addr_gen #(
        .IDX_WIDTH(IW)
    ) u_addr_gen (
        .idx      (gen_idx),
        .bte      (gen_bte),
        .next_idx (gen_next)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bte_n   = bte_q;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        acc_en  = 1'b0;
        acc_idx = widx;
        case (state)
            IDLE: begin
                if (s.cyc && s.stb) begin
                    if (!in_range) begin
                        err_n   = 1'b1;
                        state_n = CLASSIC_ACK;
                    end else begin
                        acc_en  = 1'b1;
                        acc_idx = widx;
                        ack_n   = 1'b1;
                        if (s.cti == INCR) begin
                            state_n = BURST;
                            cnt_n   = gen_next;
                            bte_n   = wb_bte_e'(s.bte);
                        end else begin
                            state_n = CLASSIC_ACK;
                        end
                    end
                end
            end
            BURST: begin
                if (!s.cyc) begin
                    state_n = IDLE;
                end else if (s.stb) begin
                    if (adr_match) begin
                        acc_en  = 1'b1;
                        acc_idx = cnt;
                        ack_n   = 1'b1;
                        cnt_n   = gen_next;
                        // Any cycle type other than INCR closes the burst after this beat.
                        if (s.cti != INCR) begin
                            state_n = CLASSIC_ACK;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            CLASSIC_ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bte_q   <= LINEAR;
            s.ack   <= 1'b0;
            s.err   <= 1'b0;
            s.dat_r <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bte_q <= bte_n;
            s.ack <= ack_n;
            s.err <= err_n;
            if (acc_en && !s.we) begin
                s.dat_r <= mem[acc_idx];
            end
        end
    end

    // Writes land in the request cycle, so a read on the next beat sees them.
    always_ff @(posedge clk) begin
        if (!rstn && acc_en && s.we) begin
            for (int b = 0; b < LANES; b++) begin
                if (s.sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= s.dat_w[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Directed and randomized checks of the Wishbone SRAM slave against an array
// model of memory and burst address sequences derived from the bus rules.
module tb_wb_sram_burst_slave;
  import wb_pkg::*;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          L2    = 12;
  localparam int          WORDS = 4096;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  wb_slave_state_e dbg_state;

  wb_sram_burst_slave #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .MEM_WORDS_LOG2(L2),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus),
    .state(dbg_state)
  );

  logic [31:0] ref_mem [WORDS];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.cyc   = 1'b0;
    bus.stb   = 1'b0;
    bus.we    = 1'b0;
    bus.cti   = 3'b000;
    bus.bte   = 2'b00;
    bus.sel   = 4'h0;
    bus.adr   = 32'h0;
    bus.dat_w = 32'h0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] sl);
    for (int b = 0; b < 4; b++)
      if (sl[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // Word visited on beat i of a burst starting at word 'start'.
  function automatic int burst_word(input int start, input int bte, input int i);
    int len;
    case (bte)
      0:       len = WORDS;
      1:       len = 4;
      2:       len = 8;
      default: len = 16;
    endcase
    return (start - (start % len)) + ((start % len + i) % len);
  endfunction

  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] sl, input logic [2:0] cti, input string tag);
    bit inr;
    int idx;
    inr = (adr >= BASE) && (adr < BASE + 32'(WORDS * 4));
    idx = int'((adr - BASE) / 4);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr;
    bus.dat_w = d; bus.sel = sl; bus.cti = cti; bus.bte = 2'b00;
    tick();
    chk({tag, ".ack"}, 32'(bus.ack), inr ? 32'd1 : 32'd0);
    chk({tag, ".err"}, 32'(bus.err), inr ? 32'd0 : 32'd1);
    if (inr && !we) chk({tag, ".dat"}, bus.dat_r, ref_mem[idx]);
    if (inr && we) model_write(idx, d, sl);
    tick();
    chk({tag, ".gap"}, {30'b0, bus.ack, bus.err}, 32'd0);
    idle_bus();
  endtask

  task automatic burst(input bit we, input int start, input int bte, input int nbeats,
                       input int stall_after, input int stall_len,
                       input int bad_beat, input logic [31:0] bad_adr, input string tag);
    int idx;
    logic [31:0] d;
    logic [3:0] sl;
    for (int i = 0; i < nbeats; i++) begin
      idx = burst_word(start, bte, i);
      d   = $urandom;
      sl  = 4'($urandom_range(0, 15));
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.bte = 2'(bte);
      bus.cti = (i == nbeats - 1) ? 3'b111 : 3'b010;
      bus.adr = (i == bad_beat) ? bad_adr : BASE + 32'(idx * 4);
      bus.dat_w = d; bus.sel = sl;
      tick();
      if (i == bad_beat) begin
        chk($sformatf("%s.b%0d.err", tag, i), {30'b0, bus.ack, bus.err}, 32'd1);
        idle_bus();
        tick();
        chk($sformatf("%s.after_err", tag), {30'b0, bus.ack, bus.err}, 32'd0);
        return;
      end
      chk($sformatf("%s.b%0d.ack", tag, i), {30'b0, bus.ack, bus.err}, 32'd2);
      if (!we) chk($sformatf("%s.b%0d.dat", tag, i), bus.dat_r, ref_mem[idx]);
      else model_write(idx, d, sl);
      if (i == stall_after && i != nbeats - 1) begin
        bus.stb = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          chk($sformatf("%s.stall%0d", tag, k), {30'b0, bus.ack, bus.err}, 32'd0);
        end
      end
    end
    idle_bus();
    tick();
    chk({tag, ".tail"}, {30'b0, bus.ack, bus.err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [2:0] cti_pick [5];
    cti_pick[0] = 3'b000; cti_pick[1] = 3'b001; cti_pick[2] = 3'b111;
    cti_pick[3] = 3'b011; cti_pick[4] = 3'b100;

    idle_bus();
    rstn = 1'b1;
    tick();
    tick();
    chk("rst.ack", 32'(bus.ack), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.dat", bus.dat_r, 32'd0);
    chk("rst.state", {30'b0, dbg_state}, {30'b0, IDLE});
    rstn = 1'b0;

    for (int w = 0; w < 64; w++) classic(1'b1, BASE + 32'(w * 4), $urandom, 4'hF, 3'b000, "fill");
    classic(1'b1, BASE + 32'((WORDS - 2) * 4), $urandom, 4'hF, 3'b000, "fill_hi0");
    classic(1'b1, BASE + 32'((WORDS - 1) * 4), $urandom, 4'hF, 3'b000, "fill_hi1");

    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, "wr10");
    classic(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, "rd10");
    chk("rd10.const", bus.dat_r, 32'hDEADBEEF);
    classic(1'b1, 32'h10, 32'h000000AA, 4'h1, 3'b000, "wr10_lane");
    classic(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, "rd10_lane");
    chk("rd10_lane.const", bus.dat_r, 32'hDEADBEAA);
    classic(1'b1, 32'h14, 32'h12345678, 4'h0, 3'b000, "wr_sel0");
    classic(1'b0, 32'h14, 32'h0, 4'hF, 3'b000, "rd_sel0");

    burst(1'b0, 6, 1, 4, -1, 0, -1, 32'h0, "wrap4_rd18");
    burst(1'b0, 1, 0, 4, 1, 2, -1, 32'h0, "stall");

    // Master abandons the cycle after two beats.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.bte = 2'b00; bus.cti = 3'b010;
    bus.adr = BASE + 32'(20 * 4);
    tick();
    chk("abort.b0.dat", bus.dat_r, ref_mem[20]);
    bus.adr = BASE + 32'(21 * 4);
    tick();
    chk("abort.b1.dat", bus.dat_r, ref_mem[21]);
    idle_bus();
    tick();
    chk("abort.noack0", {30'b0, bus.ack, bus.err}, 32'd0);
    tick();
    chk("abort.noack1", {30'b0, bus.ack, bus.err}, 32'd0);
    classic(1'b0, BASE + 32'(30 * 4), 32'h0, 4'hF, 3'b000, "abort.next");

    classic(1'b1, BASE + 32'h4000, 32'hCAFEF00D, 4'hF, 3'b000, "oor_wr");
    classic(1'b0, BASE + 32'h0, 32'h0, 4'hF, 3'b000, "oor_word0");

    burst(1'b1, 7, 0, 4, -1, 0, 1, 32'h24, "mismatch");
    classic(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, "mismatch.rd20");
    classic(1'b0, 32'h24, 32'h0, 4'hF, 3'b000, "mismatch.rd24");

    burst(1'b0, WORDS - 2, 0, 4, -1, 0, -1, 32'h0, "lin_wrap");
    burst(1'b0, WORDS - 2, 0, 4, -1, 0, 2, BASE + 32'(WORDS * 4), "lin_leave");

    // Reset pulse on beat 2 of an 8-beat read burst.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.bte = 2'b10; bus.cti = 3'b010;
    bus.adr = BASE + 32'(40 * 4);
    tick();
    chk("rstmid.b0.dat", bus.dat_r, ref_mem[40]);
    bus.adr = BASE + 32'(41 * 4);
    rstn = 1'b1;
    tick();
    chk("rstmid.ack", 32'(bus.ack), 32'd0);
    chk("rstmid.err", 32'(bus.err), 32'd0);
    chk("rstmid.dat", bus.dat_r, 32'd0);
    rstn = 1'b0;
    bus.stb = 1'b0;
    tick();
    chk("rstmid.quiet0", {30'b0, bus.ack, bus.err}, 32'd0);
    tick();
    chk("rstmid.quiet1", {30'b0, bus.ack, bus.err}, 32'd0);
    idle_bus();
    tick();
    classic(1'b0, BASE + 32'(40 * 4), 32'h0, 4'hF, 3'b000, "rstmid.keep40");
    classic(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, "rstmid.keep10");

    for (int n = 0; n < 30; n++) begin
      int kind, bte, nb, st, sa;
      bit we;
      kind = $urandom_range(0, 2);
      we   = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        classic(we, BASE + 32'($urandom_range(0, 63) * 4), $urandom,
                4'($urandom_range(0, 15)), cti_pick[$urandom_range(0, 4)],
                $sformatf("rnd%0d.cls", n));
      end else begin
        bte = $urandom_range(0, 3);
        nb  = $urandom_range(1, 8);
        st  = (bte == 0) ? $urandom_range(0, 55) : $urandom_range(0, 63);
        sa  = $urandom_range(0, 3) == 0 ? -1 : $urandom_range(0, nb - 1);
        burst(we, st, bte, nb, sa, $urandom_range(1, 3), -1, 32'h0,
              $sformatf("rnd%0d.bst", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
